// File: rtl/mem_fu_nb.sv
//============================================================================
// Module      : mem_fu_nb
// Description : Non-blocking memory functional unit. Computes effective
//               addresses, forwards stores to the store queue, tracks up to
//               PEND_DEPTH outstanding loads that retry the dcache until they
//               hit, extracts/extends load data and holds results until the
//               CDB grants them.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_fu_nb #(
    parameter int PEND_DEPTH = 4,
    parameter int XLEN       = 32,
    parameter int TAG_W      = 6,
    parameter int SQ_IDX_W   = 3
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              flush,
    input  logic                              valid,
    input  logic [3:0]                        func,
    input  logic [XLEN-1:0]                   rs1,
    input  logic [XLEN-1:0]                   rs2,
    input  logic [XLEN-1:0]                   imm,
    input  logic [SQ_IDX_W-1:0]               store_queue_idx,
    input  logic [TAG_W-1:0]                  dest_tag,
    output logic                              ready,
    output logic                              dcache_req,
    output logic [XLEN-1:0]                   dcache_addr,
    input  logic                              dcache_hit,
    input  logic [63:0]                       dcache_data,
    output logic                              sq_valid,
    output logic [XLEN-1:0]                   sq_addr,
    output logic [XLEN-1:0]                   sq_data,
    output logic [SQ_IDX_W-1:0]               sq_idx,
    output logic [1:0]                        sq_size,
    output logic                              cdb_request,
    input  logic                              cdb_grant,
    output logic [TAG_W-1:0]                  cdb_tag,
    output logic [XLEN-1:0]                   cdb_data,
    output logic [$clog2(PEND_DEPTH+1)-1:0]   pend_count
);

    localparam int c_IDX_W = $clog2(PEND_DEPTH);
    localparam int c_CNT_W = $clog2(PEND_DEPTH+1);

    localparam logic [3:0] c_FN_LB  = 4'd0;
    localparam logic [3:0] c_FN_LH  = 4'd1;
    localparam logic [3:0] c_FN_LW  = 4'd2;
    localparam logic [3:0] c_FN_LBU = 4'd4;
    localparam logic [3:0] c_FN_LHU = 4'd5;
    localparam logic [3:0] c_FN_SB  = 4'd8;
    localparam logic [3:0] c_FN_SH  = 4'd9;
    localparam logic [3:0] c_FN_SW  = 4'd10;

    // Tracking entries
    logic [PEND_DEPTH-1:0] r_valid;
    logic [PEND_DEPTH-1:0] r_done;
    logic [TAG_W-1:0]      r_tag  [PEND_DEPTH];
    logic [XLEN-1:0]       r_addr [PEND_DEPTH];
    logic [3:0]            r_func [PEND_DEPTH];
    logic [XLEN-1:0]       r_data [PEND_DEPTH];

    logic [XLEN-1:0]    w_addr;
    logic               w_is_load;
    logic               w_is_store;
    logic               w_new_load;
    logic [c_CNT_W-1:0] w_count;
    logic [c_IDX_W-1:0] w_free_idx;
    logic               w_retry_found;
    logic [c_IDX_W-1:0] w_retry_idx;
    logic               w_done_found;
    logic [c_IDX_W-1:0] w_done_idx;
    logic [XLEN-1:0]    w_look_addr;
    logic [3:0]         w_look_func;
    logic [XLEN-1:0]    w_look_data;
    logic               w_look_hit;

    // Pick the byte/half/word out of the 8-byte block and extend it.
    // Halfword access ignores addr[0]; there is no misalignment trap.
    function automatic logic [XLEN-1:0] f_extract(
        input logic [63:0] blk,
        input logic [2:0]  off,
        input logic [3:0]  fn
    );
        logic [7:0]      w_b;
        logic [15:0]     w_h;
        logic [31:0]     w_w;
        logic [XLEN-1:0] w_r;
        w_b = blk[{off, 3'b000} +: 8];
        w_h = blk[{off[2:1], 4'b0000} +: 16];
        w_w = blk[{off[2], 5'b00000} +: 32];
        case (fn)
            c_FN_LB:  w_r = XLEN'($signed(w_b));
            c_FN_LH:  w_r = XLEN'($signed(w_h));
            c_FN_LBU: w_r = XLEN'(w_b);
            c_FN_LHU: w_r = XLEN'(w_h);
            default:  w_r = XLEN'($signed(w_w));
        endcase
        return w_r;
    endfunction

    // Effective address, wraps modulo 2^XLEN
    assign w_addr = rs1 + imm;

    // Decode the issued operation; unlisted encodings do nothing
    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        if (valid) begin
            case (func)
                c_FN_LB, c_FN_LH, c_FN_LW, c_FN_LBU, c_FN_LHU: w_is_load  = 1'b1;
                c_FN_SB, c_FN_SH, c_FN_SW:                     w_is_store = 1'b1;
                default: ;
            endcase
        end
    end

    // Occupancy count of the tracking entries
    always_comb begin
        w_count = '0;
        for (int i = 0; i < PEND_DEPTH; i++) begin
            w_count = w_count + c_CNT_W'(r_valid[i]);
        end
    end

    assign pend_count = w_count;
    assign ready      = (w_count < c_CNT_W'(PEND_DEPTH));
    assign w_new_load = w_is_load && ready;

    // Lowest-index searches: free slot, pending retry, completed result
    always_comb begin
        w_free_idx    = '0;
        w_retry_found = 1'b0;
        w_retry_idx   = '0;
        w_done_found  = 1'b0;
        w_done_idx    = '0;
        for (int i = PEND_DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_idx = c_IDX_W'(i);
            end
            if (r_valid[i] && !r_done[i]) begin
                w_retry_found = 1'b1;
                w_retry_idx   = c_IDX_W'(i);
            end
            if (r_valid[i] && r_done[i]) begin
                w_done_found = 1'b1;
                w_done_idx   = c_IDX_W'(i);
            end
        end
    end

    // Dcache port arbitration: a newly issued load beats any retry
    always_comb begin
        w_look_addr = '0;
        w_look_func = 4'd0;
        if (w_new_load) begin
            w_look_addr = w_addr;
            w_look_func = func;
        end else if (w_retry_found) begin
            w_look_addr = r_addr[w_retry_idx];
            w_look_func = r_func[w_retry_idx];
        end
        dcache_req  = w_new_load || w_retry_found;
        dcache_addr = dcache_req ? {w_look_addr[XLEN-1:3], 3'b000} : '0;
        w_look_hit  = dcache_req && dcache_hit;
        w_look_data = f_extract(dcache_data, w_look_addr[2:0], w_look_func);
    end

    // Store queue write is a pure same-cycle pass-through
    always_comb begin
        sq_valid = w_is_store;
        sq_addr  = w_is_store ? w_addr : '0;
        sq_data  = w_is_store ? rs2 : '0;
        sq_idx   = w_is_store ? store_queue_idx : '0;
        sq_size  = w_is_store ? func[1:0] : 2'b00;
    end

    // Present the lowest completed entry to the CDB
    always_comb begin
        cdb_request = w_done_found;
        cdb_tag     = w_done_found ? r_tag[w_done_idx]  : '0;
        cdb_data    = w_done_found ? r_data[w_done_idx] : '0;
    end

    // Entry state: flush wins over free, hit and allocate in the same cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_done  <= '0;
            for (int i = 0; i < PEND_DEPTH; i++) begin
                r_tag[i]  <= '0;
                r_addr[i] <= '0;
                r_func[i] <= 4'd0;
                r_data[i] <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
            r_done  <= '0;
        end else begin
            // The granted slot was occupied, so it never collides with the
            // free slot chosen for allocation this cycle.
            if (cdb_request && cdb_grant) begin
                r_valid[w_done_idx] <= 1'b0;
                r_done[w_done_idx]  <= 1'b0;
            end
            if (w_look_hit && !w_new_load) begin
                r_done[w_retry_idx] <= 1'b1;
                r_data[w_retry_idx] <= w_look_data;
            end
            if (w_new_load) begin
                r_valid[w_free_idx] <= 1'b1;
                r_done[w_free_idx]  <= dcache_hit;
                r_tag[w_free_idx]   <= dest_tag;
                r_addr[w_free_idx]  <= w_addr;
                r_func[w_free_idx]  <= func;
                r_data[w_free_idx]  <= w_look_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_fu_nb.sv
//============================================================================
// Module      : tb_mem_fu_nb
// Description : Scoreboard bench for mem_fu_nb with a behavioural model of
//               the load tracker, dcache stand-in and store/CDB queues.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_fu_nb;

    localparam int P = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        valid = 1'b0;
    logic [3:0]  func  = 4'd0;
    logic [31:0] rs1 = '0, rs2 = '0, imm = '0;
    logic [2:0]  store_queue_idx = '0;
    logic [5:0]  dest_tag = '0;
    logic        ready, dcache_req;
    logic [31:0] dcache_addr;
    logic        dcache_hit = 1'b0;
    logic [63:0] dcache_data = '0;
    logic        sq_valid;
    logic [31:0] sq_addr, sq_data;
    logic [2:0]  sq_idx;
    logic [1:0]  sq_size;
    logic        cdb_request;
    logic        cdb_grant = 1'b0;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic [2:0]  pend_count;

    mem_fu_nb #(.PEND_DEPTH(P), .XLEN(32), .TAG_W(6), .SQ_IDX_W(3)) dut (
        .clock(clock), .reset(reset), .flush(flush), .valid(valid), .func(func),
        .rs1(rs1), .rs2(rs2), .imm(imm), .store_queue_idx(store_queue_idx),
        .dest_tag(dest_tag), .ready(ready), .dcache_req(dcache_req),
        .dcache_addr(dcache_addr), .dcache_hit(dcache_hit), .dcache_data(dcache_data),
        .sq_valid(sq_valid), .sq_addr(sq_addr), .sq_data(sq_data), .sq_idx(sq_idx),
        .sq_size(sq_size), .cdb_request(cdb_request), .cdb_grant(cdb_grant),
        .cdb_tag(cdb_tag), .cdb_data(cdb_data), .pend_count(pend_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        rdy;
        logic [2:0]  cnt;
        logic        req;
        logic [31:0] la;
        logic        creq;
        logic [5:0]  ctag;
        logic [31:0] cdata;
        logic        sqv;
    } st_t;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  i;
        logic [1:0]  s;
    } sq_t;
    typedef struct packed {
        logic [5:0]  t;
        logic [31:0] d;
    } cdb_t;

    st_t  stq[$];
    sq_t  sqq[$];
    cdb_t cdq[$];

    int total = 0;
    int bad   = 0;

    // Reference model: one record per tracked load, indexed by slot
    bit          m_v    [P];
    bit          m_d    [P];
    logic [5:0]  m_tag  [P];
    logic [31:0] m_addr [P];
    logic [31:0] m_data [P];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_ld(input logic [3:0] f);
        return (f == 4'd0) || (f == 4'd1) || (f == 4'd2) || (f == 4'd4) || (f == 4'd5);
    endfunction

    function automatic bit is_st(input logic [3:0] f);
        return (f == 4'd8) || (f == 4'd9) || (f == 4'd10);
    endfunction

    // Stand-in dcache contents keyed by aligned block address
    function automatic logic [63:0] blk_of(input logic [31:0] a);
        if (a == 32'h1000) return 64'hAABBCCDD_11223344;
        if (a == 32'h2000) return 64'h80112233_44556677;
        return {(a * 32'h9E3779B1) ^ 32'h0F0F1234, a ^ 32'hC001D00D};
    endfunction

    // Load result from block, address and opcode, by shifting and masking
    function automatic logic [31:0] m_ext(input logic [63:0] blk, input logic [31:0] a,
                                          input logic [3:0] f);
        int          o;
        logic [63:0] t;
        logic [31:0] r;
        o = int'(a % 8);
        if (f == 4'd0 || f == 4'd4) begin
            t = blk >> (8 * o);
            r = t[31:0] & 32'hFF;
            if (f == 4'd0 && r >= 32'd128) r = r - 32'd256;
        end else if (f == 4'd1 || f == 4'd5) begin
            t = blk >> (16 * (o / 2));
            r = t[31:0] & 32'hFFFF;
            if (f == 4'd1 && r >= 32'd32768) r = r - 32'd65536;
        end else begin
            t = blk >> (32 * (o / 4));
            r = t[31:0];
        end
        return r;
    endfunction

    function automatic int m_cnt();
        int c = 0;
        for (int i = 0; i < P; i++) c += int'(m_v[i]);
        return c;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < P; i++) begin
            m_v[i] = 1'b0;
            m_d[i] = 1'b0;
        end
    endtask

    // Drive one cycle of stimulus, predict the cycle's observations, then
    // advance the model to the state after the next clock edge.
    task automatic drive(input bit v, input logic [3:0] f, input logic [31:0] a1,
                         input logic [31:0] a2, input logic [31:0] im,
                         input logic [2:0] sqi, input logic [5:0] tg,
                         input bit hit, input bit gnt, input bit fl);
        int          cnt, j, k, fr;
        bit          rdy, nl, req, creq;
        logic [31:0] ea, la, blk_a;
        logic [63:0] blk;
        st_t         s;
        sq_t         q;
        cdb_t        c;
        @(posedge clock);
        #1;
        valid = v; func = f; rs1 = a1; rs2 = a2; imm = im;
        store_queue_idx = sqi; dest_tag = tg; cdb_grant = gnt; flush = fl;
        ea  = a1 + im;
        cnt = m_cnt();
        rdy = (cnt < P);
        nl  = v && is_ld(f) && rdy;
        j = -1; k = -1; fr = -1;
        for (int i = P - 1; i >= 0; i--) begin
            if (m_v[i] && !m_d[i]) j = i;
            if (m_v[i] && m_d[i])  k = i;
            if (!m_v[i])           fr = i;
        end
        req   = nl || (j >= 0);
        la    = nl ? ea : ((j >= 0) ? m_addr[j] : 32'h0);
        blk_a = la & 32'hFFFF_FFF8;
        blk   = blk_of(blk_a);
        dcache_hit  = hit;
        dcache_data = req ? blk : 64'h0;
        creq = (k >= 0);
        s.rdy   = rdy;
        s.cnt   = 3'(cnt);
        s.req   = req;
        s.la    = req ? blk_a : 32'h0;
        s.creq  = creq;
        s.ctag  = creq ? m_tag[k] : 6'h0;
        s.cdata = creq ? m_data[k] : 32'h0;
        s.sqv   = v && is_st(f);
        stq.push_back(s);
        if (v && is_st(f)) begin
            q.a = ea; q.d = a2; q.i = sqi; q.s = f[1:0];
            sqq.push_back(q);
        end
        if (creq && gnt) begin
            c.t = m_tag[k]; c.d = m_data[k];
            cdq.push_back(c);
        end
        if (fl) begin
            m_clear();
        end else begin
            if (creq && gnt) m_v[k] = 1'b0;
            if (nl) begin
                m_v[fr] = 1'b1; m_d[fr] = hit; m_tag[fr] = tg; m_addr[fr] = ea;
                m_data[fr] = m_ext(blk, ea, f);
            end else if (j >= 0 && hit) begin
                m_d[j] = 1'b1;
                m_data[j] = m_ext(blk, m_addr[j], m_func_of(j));
            end
        end
    endtask

    // Opcode of each tracked load, kept beside the model entries
    logic [3:0] m_fn [P];
    function automatic logic [3:0] m_func_of(input int j);
        return m_fn[j];
    endfunction

    // Wrapper that also records the opcode for the slot a load lands in
    task automatic issue(input bit v, input logic [3:0] f, input logic [31:0] a1,
                         input logic [31:0] a2, input logic [31:0] im,
                         input logic [2:0] sqi, input logic [5:0] tg,
                         input bit hit, input bit gnt, input bit fl);
        int fr;
        fr = -1;
        for (int i = P - 1; i >= 0; i--) if (!m_v[i]) fr = i;
        if (fr >= 0) m_fn[fr] = f;
        drive(v, f, a1, a2, im, sqi, tg, hit, gnt, fl);
    endtask

    task automatic idle(input bit hit, input bit gnt);
        drive(1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 3'd0, 6'd0, hit, gnt, 1'b0);
    endtask

    // Monitor: compare per-cycle status and pop presented store/CDB results
    always @(negedge clock) begin
        st_t  s;
        sq_t  q;
        cdb_t c;
        if (!reset) begin
            if (valid && is_ld(func)) chk("load_issued_with_ready", ready, 1);
            if (stq.size() > 0) begin
                s = stq.pop_front();
                chk("ready", ready, s.rdy);
                chk("pend_count", pend_count, s.cnt);
                chk("dcache_req", dcache_req, s.req);
                chk("dcache_addr", dcache_addr, s.la);
                chk("cdb_request", cdb_request, s.creq);
                chk("sq_valid", sq_valid, s.sqv);
                if (s.creq) begin
                    chk("cdb_tag_present", cdb_tag, s.ctag);
                    chk("cdb_data_present", cdb_data, s.cdata);
                end
            end
            if (sq_valid) begin
                total++;
                if (sqq.size() == 0) begin
                    bad++;
                    $display("FAIL sq_unexpected actual=1 required=0 at %0t", $time);
                end else begin
                    total--;
                    q = sqq.pop_front();
                    chk("sq_addr", sq_addr, q.a);
                    chk("sq_data", sq_data, q.d);
                    chk("sq_idx", sq_idx, q.i);
                    chk("sq_size", sq_size, q.s);
                end
            end
            if (cdb_request && cdb_grant) begin
                total++;
                if (cdq.size() == 0) begin
                    bad++;
                    $display("FAIL cdb_unexpected actual=1 required=0 at %0t", $time);
                end else begin
                    total--;
                    c = cdq.pop_front();
                    chk("cdb_tag", cdb_tag, c.t);
                    chk("cdb_data", cdb_data, c.d);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          v, hit, gnt, fl;
        logic [3:0]  f;
        logic [31:0] a1, im;
        m_clear();
        #2;
        chk("rst_ready", ready, 1);
        chk("rst_dcache_req", dcache_req, 0);
        chk("rst_dcache_addr", dcache_addr, 0);
        chk("rst_cdb_request", cdb_request, 0);
        chk("rst_cdb_tag", cdb_tag, 0);
        chk("rst_cdb_data", cdb_data, 0);
        chk("rst_pend_count", pend_count, 0);
        chk("rst_sq_valid", sq_valid, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // LW hit at 0x1004
        issue(1, 4'd2, 32'h1000, 32'h0, 32'd4, 3'd0, 6'd5, 1, 0, 0);
        @(negedge clock); #1;
        chk("lw_dcache_addr", dcache_addr, 32'h1000);
        idle(0, 0);
        @(negedge clock); #1;
        chk("lw_cdb_request", cdb_request, 1);
        chk("lw_cdb_data", cdb_data, 32'hAABBCCDD);
        chk("lw_cdb_tag", cdb_tag, 6'd5);
        idle(0, 1);
        idle(0, 0);
        @(negedge clock); #1;
        chk("lw_pend_after_grant", pend_count, 0);

        // LB and LBU of byte 7 = 0x80
        issue(1, 4'd0, 32'h2000, 32'h0, 32'd7, 3'd0, 6'd7, 1, 0, 0);
        issue(1, 4'd4, 32'h2000, 32'h0, 32'd7, 3'd0, 6'd8, 1, 0, 0);
        idle(0, 1);
        @(negedge clock); #1;
        chk("lb_sign", cdb_data, 32'hFFFFFF80);
        idle(0, 1);
        @(negedge clock); #1;
        chk("lbu_zero", cdb_data, 32'h00000080);
        idle(0, 0);

        // LH at 0x3002: three misses then a hit
        issue(1, 4'd1, 32'h3000, 32'h0, 32'd2, 3'd0, 6'd9, 0, 0, 0);
        @(negedge clock); #1;
        chk("retry_addr0", dcache_addr, 32'h3000);
        for (int i = 0; i < 2; i++) begin
            idle(0, 0);
            @(negedge clock); #1;
            chk("retry_addr_miss", dcache_addr, 32'h3000);
        end
        idle(1, 0);
        @(negedge clock); #1;
        chk("retry_addr_hit", dcache_addr, 32'h3000);
        chk("retry_no_req_yet", cdb_request, 0);
        idle(0, 0);
        @(negedge clock); #1;
        chk("retry_cdb_request", cdb_request, 1);
        idle(0, 1);
        idle(0, 0);

        // Fill to full with misses, store while full, grant with nothing done
        for (int i = 0; i < P; i++)
            issue(1, 4'd2, 32'h4000 + 32'(8 * i), 32'h0, 32'h0, 3'd0, 6'(10 + i), 0, 0, 0);
        issue(1, 4'd10, 32'h5000, 32'h1234, 32'h0, 3'd3, 6'd0, 0, 1, 0);
        @(negedge clock); #1;
        chk("full_ready", ready, 0);
        chk("full_pend", pend_count, 4);
        chk("full_sq_valid", sq_valid, 1);
        chk("full_sq_size", sq_size, 2);
        idle(0, 0);
        @(negedge clock); #1;
        chk("full_grant_frees_nothing", pend_count, 4);
        drive(0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(0, 0);

        // Slots 1 and 3 complete, grant held high
        issue(1, 4'd2, 32'h4100, 32'h0, 32'h0, 3'd0, 6'd20, 0, 0, 0);
        issue(1, 4'd2, 32'h4108, 32'h0, 32'h0, 3'd0, 6'd21, 1, 0, 0);
        issue(1, 4'd2, 32'h4110, 32'h0, 32'h0, 3'd0, 6'd22, 0, 0, 0);
        issue(1, 4'd2, 32'h4118, 32'h0, 32'h0, 3'd0, 6'd23, 1, 0, 0);
        idle(0, 1);
        @(negedge clock); #1;
        chk("order_first", cdb_tag, 6'd21);
        idle(0, 1);
        @(negedge clock); #1;
        chk("order_second", cdb_tag, 6'd23);
        idle(0, 1);
        @(negedge clock); #1;
        chk("order_drained", cdb_request, 0);
        drive(0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Flush together with a hitting load and a grant
        issue(1, 4'd2, 32'h4200, 32'h0, 32'h0, 3'd0, 6'd30, 1, 0, 0);
        issue(1, 4'd2, 32'h4208, 32'h0, 32'h0, 3'd0, 6'd31, 1, 1, 1);
        idle(0, 0);
        @(negedge clock); #1;
        chk("flush_pend", pend_count, 0);
        chk("flush_cdb_request", cdb_request, 0);

        // Asynchronous reset while a load is retrying
        issue(1, 4'd2, 32'h6000, 32'h0, 32'h0, 3'd0, 6'd40, 0, 0, 0);
        idle(0, 0);
        @(negedge clock); #1;
        chk("pre_reset_retry", dcache_req, 1);
        reset = 1'b1;
        #1;
        chk("arst_dcache_req", dcache_req, 0);
        chk("arst_dcache_addr", dcache_addr, 0);
        chk("arst_pend", pend_count, 0);
        chk("arst_ready", ready, 1);
        chk("arst_cdb_request", cdb_request, 0);
        m_clear();
        @(posedge clock); #1;
        reset = 1'b0;

        // Randomised traffic
        for (int n = 0; n < 1500; n++) begin
            v   = ($urandom_range(0, 3) != 0);
            f   = 4'($urandom_range(0, 15));
            if (v && is_ld(f) && m_cnt() >= P) f = 4'($urandom_range(8, 15));
            a1  = $urandom & 32'h0000FFFF;
            im  = 32'($urandom_range(0, 64));
            if ($urandom_range(0, 31) == 0) begin
                a1 = 32'hFFFF_FFF0;
                im = 32'($urandom_range(0, 40));
            end
            hit = $urandom_range(0, 1) == 1;
            gnt = $urandom_range(0, 9) < 6;
            fl  = $urandom_range(0, 49) == 0;
            issue(v, f, a1, $urandom, im, 3'($urandom_range(0, 7)),
                  6'($urandom_range(0, 63)), hit, gnt, fl);
        end
        for (int n = 0; n < 20; n++) idle(1, 1);
        @(negedge clock); #1;
        chk("end_pend", pend_count, 0);
        chk("end_sq_leftover", sqq.size(), 0);
        chk("end_cdb_leftover", cdq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
